// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and encodings for the RV32I pipeline hazard controller.
// Holds the sequencer state encodings, the forwarding select codes and the register-match helper.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // x0 is hardwired to zero, so a write to it never produces a forwardable value.
  function automatic logic reg_match(input logic we, input logic [4:0] rd, input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/forwarding_unit.sv
// EX-stage operand forwarding selects; purely combinational and active in every state.
// The MEM stage holds the younger result, so it is checked before WB.
module forwarding_unit
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] ID_EX_RS1,
  input  logic [4:0] ID_EX_RS2,
  input  logic [4:0] EX_MEM_RD,
  input  logic       EX_MEM_regwrite,
  input  logic [4:0] MEM_WB_RD,
  input  logic       MEM_WB_regwrite,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE
);

  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (reg_match(EX_MEM_regwrite, EX_MEM_RD, ID_EX_RS1))
      ForwardAE = FWD_MEM;
    else if (reg_match(MEM_WB_regwrite, MEM_WB_RD, ID_EX_RS1))
      ForwardAE = FWD_WB;
    if (reg_match(EX_MEM_regwrite, EX_MEM_RD, ID_EX_RS2))
      ForwardBE = FWD_MEM;
    else if (reg_match(MEM_WB_regwrite, MEM_WB_RD, ID_EX_RS2))
      ForwardBE = FWD_WB;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: boot fill, load-use and
// branch hazards, data-memory wait with timeout, plus saturating stall/flush counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_ID_RS1,
  input  logic [4:0]       IF_ID_RS2,
  input  logic [4:0]       ID_EX_RS1,
  input  logic [4:0]       ID_EX_RS2,
  input  logic [4:0]       ID_EX_RD,
  input  logic             ID_EX_memread,
  input  logic [4:0]       EX_MEM_RD,
  input  logic             EX_MEM_regwrite,
  input  logic [4:0]       MEM_WB_RD,
  input  logic             MEM_WB_regwrite,
  input  logic             PCSrcE,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int BW = $clog2(BOOT_CYCLES) + 1;
  localparam int WW = $clog2(MEM_TIMEOUT) + 1;

  state_t          state;
  state_t          state_next;
  logic [BW-1:0]   boot_cnt;
  logic [WW-1:0]   wait_cnt;
  logic            load_use;
  logic            run_like;
  logic            mem_stall;
  logic            branch_flush;

  forwarding_unit u_fwd (
    .ID_EX_RS1      (ID_EX_RS1),
    .ID_EX_RS2      (ID_EX_RS2),
    .EX_MEM_RD      (EX_MEM_RD),
    .EX_MEM_regwrite(EX_MEM_regwrite),
    .MEM_WB_RD      (MEM_WB_RD),
    .MEM_WB_regwrite(MEM_WB_regwrite),
    .ForwardAE      (ForwardAE),
    .ForwardBE      (ForwardBE)
  );

  // A MEM_WAIT cycle that sees dmem_ready already behaves like RUN, so stalls drop at once.
  always_comb begin
    load_use     = ID_EX_memread && (ID_EX_RD != 5'd0) &&
                   ((ID_EX_RD == IF_ID_RS1) || (ID_EX_RD == IF_ID_RS2));
    run_like     = (state == ST_RUN) || ((state == ST_MEM_WAIT) && dmem_ready);
    mem_stall    = ((state == ST_MEM_WAIT) && !dmem_ready) ||
                   ((state == ST_RUN) && dmem_req && !dmem_ready);
    branch_flush = run_like && !mem_stall && PCSrcE;
  end

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (state == ST_BOOT) begin
      StallF = 1'b1;
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if ((state == ST_ERROR) || mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (branch_flush) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (run_like && load_use) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // Ready on the final allowed wait cycle still returns to RUN rather than ERROR.
  always_comb begin
    state_next = state;
    case (state)
      ST_BOOT:     if (boot_cnt == BW'(BOOT_CYCLES - 1)) state_next = ST_RUN;
      ST_RUN:      if (dmem_req && !dmem_ready) state_next = ST_MEM_WAIT;
      ST_MEM_WAIT: begin
        if (dmem_ready)
          state_next = ST_RUN;
        else if (wait_cnt == WW'(MEM_TIMEOUT - 1))
          state_next = ST_ERROR;
      end
      ST_ERROR:    state_next = ST_ERROR;
      default:     state_next = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_BOOT;
      boot_cnt  <= '0;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ST_BOOT)
        boot_cnt <= boot_cnt + BW'(1);
      if (state == ST_MEM_WAIT)
        wait_cnt <= wait_cnt + WW'(1);
      else
        wait_cnt <= '0;
      if ((state == ST_MEM_WAIT) && (state_next == ST_ERROR))
        mem_err <= 1'b1;
      if (((state == ST_RUN) || (state == ST_MEM_WAIT)) && StallF && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (branch_flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl (MEM_TIMEOUT=8, CNT_W=4).
// Expected outputs are queued with each stimulus and checked at the following negedge.
module tb_pipeline_hazard_ctrl;

  typedef struct {
    logic [4:0] if_rs1, if_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       ex_memread, mem_rw, wb_rw, pcsrc, dreq, dready;
  } stim_t;

  typedef struct packed {
    logic [6:0] sf;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       err;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  localparam logic [6:0] BOOTV = 7'b1000110;
  localparam logic [6:0] NONE  = 7'b0000000;
  localparam logic [6:0] LW    = 7'b1100010;
  localparam logic [6:0] BR    = 7'b0000110;
  localparam logic [6:0] MW    = 7'b1111001;

  logic       clk, rst;
  logic [4:0] IF_ID_RS1, IF_ID_RS2, ID_EX_RS1, ID_EX_RS2, ID_EX_RD, EX_MEM_RD, MEM_WB_RD;
  logic       ID_EX_memread, EX_MEM_regwrite, MEM_WB_regwrite, PCSrcE, dmem_req, dmem_ready;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
  logic [1:0] ForwardAE, ForwardBE;
  logic [3:0] stall_cnt, flush_cnt;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic [3:0] model_s, model_f;

  pipeline_hazard_ctrl #(.BOOT_CYCLES(2), .MEM_TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_RS1(IF_ID_RS1), .IF_ID_RS2(IF_ID_RS2),
    .ID_EX_RS1(ID_EX_RS1), .ID_EX_RS2(ID_EX_RS2), .ID_EX_RD(ID_EX_RD),
    .ID_EX_memread(ID_EX_memread),
    .EX_MEM_RD(EX_MEM_RD), .EX_MEM_regwrite(EX_MEM_regwrite),
    .MEM_WB_RD(MEM_WB_RD), .MEM_WB_regwrite(MEM_WB_regwrite),
    .PCSrcE(PCSrcE), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t s;
    s.if_rs1 = 0; s.if_rs2 = 0; s.ex_rs1 = 0; s.ex_rs2 = 0; s.ex_rd = 0;
    s.mem_rd = 0; s.wb_rd = 0; s.ex_memread = 0; s.mem_rw = 0; s.wb_rw = 0;
    s.pcsrc = 0; s.dreq = 0; s.dready = 0;
    return s;
  endfunction

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic apply_stimulus(input stim_t s, input exp_t e);
    IF_ID_RS1 = s.if_rs1; IF_ID_RS2 = s.if_rs2;
    ID_EX_RS1 = s.ex_rs1; ID_EX_RS2 = s.ex_rs2; ID_EX_RD = s.ex_rd;
    ID_EX_memread = s.ex_memread;
    EX_MEM_RD = s.mem_rd; EX_MEM_regwrite = s.mem_rw;
    MEM_WB_RD = s.wb_rd;  MEM_WB_regwrite = s.wb_rw;
    PCSrcE = s.pcsrc; dmem_req = s.dreq; dmem_ready = s.dready;
    exp_q.push_back(e);
  endtask

  task automatic check_output();
    exp_t e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      cmp("scoreboard_empty", 16'd0, 16'd1);
    end else begin
      e = exp_q.pop_front();
      cmp("stall_flush", 16'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}), 16'(e.sf));
      cmp("ForwardAE", 16'(ForwardAE), 16'(e.fa));
      cmp("ForwardBE", 16'(ForwardBE), 16'(e.fb));
      cmp("mem_err", 16'(mem_err), 16'(e.err));
      cmp("stall_cnt", 16'(stall_cnt), 16'(e.sc));
      cmp("flush_cnt", 16'(flush_cnt), 16'(e.fc));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_step(input stim_t s, input logic [6:0] sf, input logic [1:0] fa,
                          input logic [1:0] fb, input logic err, input logic inc_s,
                          input logic inc_f);
    exp_t e;
    e.sf = sf; e.fa = fa; e.fb = fb; e.err = err; e.sc = model_s; e.fc = model_f;
    apply_stimulus(s, e);
    check_output();
    if (inc_s && model_s != 4'hF) model_s = model_s + 4'd1;
    if (inc_f && model_f != 4'hF) model_f = model_f + 4'd1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_s = 0;
    model_f = 0;
    run_step(idle(), BOOTV, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    run_step(idle(), BOOTV, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    run_step(idle(), BOOTV, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    stim_t s;
    rst = 1'b0;
    model_s = 0;
    model_f = 0;
    s = idle();
    IF_ID_RS1 = 0; IF_ID_RS2 = 0; ID_EX_RS1 = 0; ID_EX_RS2 = 0; ID_EX_RD = 0;
    ID_EX_memread = 0; EX_MEM_RD = 0; EX_MEM_regwrite = 0; MEM_WB_RD = 0;
    MEM_WB_regwrite = 0; PCSrcE = 0; dmem_req = 0; dmem_ready = 0;
    @(posedge clk);
    #1;

    $display("[TB] reset and boot sequence");
    run_step(idle(), BOOTV, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    do_reset();
    run_step(idle(), NONE, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    $display("[TB] forwarding");
    s = idle();
    s.mem_rd = 5; s.mem_rw = 1; s.wb_rd = 5; s.wb_rw = 1; s.ex_rs1 = 5; s.ex_rs2 = 7;
    run_step(s, NONE, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
    s.mem_rw = 0; s.ex_rs2 = 5;
    run_step(s, NONE, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    s.mem_rw = 1; s.mem_rd = 9; s.ex_rs2 = 9;
    run_step(s, NONE, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0);
    s = idle();
    s.mem_rw = 1; s.wb_rw = 1;
    run_step(s, NONE, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    $display("[TB] load-use and branch");
    s = idle();
    s.ex_memread = 1; s.ex_rd = 3; s.if_rs2 = 3;
    run_step(s, LW, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    run_step(idle(), NONE, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    s.pcsrc = 1;
    run_step(s, BR, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    run_step(idle(), NONE, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    s = idle();
    s.ex_memread = 1; s.ex_rd = 0; s.if_rs1 = 0;
    run_step(s, NONE, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    $display("[TB] memory wait with branch pending");
    do_reset();
    s = idle();
    s.dreq = 1; s.pcsrc = 1; s.ex_memread = 1; s.ex_rd = 4; s.if_rs1 = 4;
    run_step(s, MW, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    s.ex_memread = 0;
    run_step(s, MW, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    run_step(s, MW, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    s.dready = 1;
    run_step(s, BR, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    run_step(idle(), NONE, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    $display("[TB] ready on the last allowed wait cycle");
    do_reset();
    s = idle();
    s.dreq = 1;
    for (int i = 0; i < 8; i++)
      run_step(s, MW, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    s.dready = 1;
    run_step(s, NONE, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    run_step(idle(), NONE, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    $display("[TB] memory timeout");
    do_reset();
    s = idle();
    s.dreq = 1;
    for (int i = 0; i < 9; i++)
      run_step(s, MW, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    s.mem_rd = 6; s.mem_rw = 1; s.ex_rs1 = 6; s.pcsrc = 1;
    run_step(s, MW, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0);
    s.dready = 1;
    run_step(s, MW, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0);
    do_reset();
    run_step(idle(), NONE, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    $display("[TB] stall counter saturation");
    s = idle();
    s.ex_memread = 1; s.ex_rd = 12; s.if_rs1 = 12;
    for (int i = 0; i < 20; i++)
      run_step(s, LW, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    run_step(idle(), NONE, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
